// File: rtl/dense1_bn_relu6_requant_pkg.sv
// Shared CNN-engine definitions for the dense-1 BN/ReLU6 requantiser:
// default widths, activation/index types and the neuron counter step.
package dense1_bn_relu6_requant_pkg;

    // Default datapath geometry
    localparam int ACC_W_DEF     = 32;  // signed dense-1 accumulator width
    localparam int SHIFT_DEF     = 12;  // right shift after the scale multiply
    localparam int RELU6_MAX_DEF = 96;  // 6.0 in unsigned Q4.4
    localparam int N_NEURONS_DEF = 128; // neurons per dense-1 output vector

    // Fixed field widths
    localparam int IDX_W   = 7;  // neuron index width
    localparam int ADDR_W  = 8;  // scale ROM address width
    localparam int SCALE_W = 8;  // unsigned per-neuron scale width
    localparam int DATA_W  = 8;  // unsigned activation width

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] act_t;

    // Neuron counter step with wrap from n-1 back to 0
    function automatic idx_t next_idx(input idx_t cur, input int n);
        if (cur == idx_t'(n - 1)) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/dense1_bn_relu6_requant_if.sv
// Stream and scale-ROM signals of the dense-1 requantiser. The slave
// modport is the block's view; the master modport is the surrounding
// fabric (accumulator source, scale ROM and activation sink).
interface dense1_bn_relu6_requant_if
    import dense1_bn_relu6_requant_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);

    // Accumulator input stream
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] in_acc;

    // Per-neuron scale ROM lookup
    logic [ADDR_W-1:0]       rom_addr;
    logic [SCALE_W-1:0]      rom_data;

    // Activation output stream
    logic                    out_valid;
    logic                    out_ready;
    act_t                    out_data;
    idx_t                    out_idx;
    logic                    out_last;

    modport slave (
        input  in_valid,
        input  in_acc,
        input  rom_data,
        input  out_ready,
        output in_ready,
        output rom_addr,
        output out_valid,
        output out_data,
        output out_idx,
        output out_last
    );

    modport master (
        output in_valid,
        output in_acc,
        output rom_data,
        output out_ready,
        input  in_ready,
        input  rom_addr,
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last
    );

endinterface

// File: rtl/dense1_mul_round_clamp.sv
// Multiply and round/clamp stages of the dense-1 requantiser. Takes the
// captured accumulator/scale pair, forms the full-width signed product,
// rounds half-up, shifts and clamps into the unsigned ReLU6 range. Both
// stages advance together on en; clear empties them.
module dense1_mul_round_clamp
    import dense1_bn_relu6_requant_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int SHIFT     = SHIFT_DEF,
    parameter int RELU6_MAX = RELU6_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    vld_p0,
    input  logic signed [ACC_W-1:0] acc_p0,
    input  logic [SCALE_W-1:0]      scale_p0,
    input  idx_t                    idx_p0,
    input  logic                    last_p0,
    output logic                    out_valid,
    output act_t                    out_data,
    output idx_t                    out_idx,
    output logic                    out_last
);

    // Product holds ACC_W x (SCALE_W+1) signed bits without truncation
    localparam int PROD_W = ACC_W + SCALE_W + 1;
    localparam logic signed [PROD_W-1:0] ROUND_K = PROD_W'(1) << (SHIFT - 1);
    localparam logic signed [PROD_W-1:0] MAX_EXT = PROD_W'(RELU6_MAX);

    // Half-up rounding: bias by half an LSB of the result, then floor-shift
    function automatic logic signed [PROD_W-1:0] round_half_up(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] biased;
        biased = p + ROUND_K;
        return biased >>> SHIFT;
    endfunction

    // ReLU6 saturation into the unsigned activation range
    function automatic act_t clamp_relu6(input logic signed [PROD_W-1:0] v);
        if (v[PROD_W-1]) begin
            return '0;
        end
        if (v > MAX_EXT) begin
            return act_t'(RELU6_MAX);
        end
        return v[DATA_W-1:0];
    endfunction

    logic signed [PROD_W-1:0] acc_ext;
    logic signed [PROD_W-1:0] scale_ext;
    logic signed [PROD_W-1:0] product;

    // Scale is unsigned: zero-extend it so the signed multiply treats it as positive
    assign acc_ext   = {{(PROD_W - ACC_W){acc_p0[ACC_W-1]}}, acc_p0};
    assign scale_ext = {{(PROD_W - SCALE_W){1'b0}}, scale_p0};
    assign product   = acc_ext * scale_ext;

    logic signed [PROD_W-1:0] product_p1;
    idx_t                     idx_p1;
    logic                     last_p1;
    logic                     vld_p1;

    logic                     vld_p2;
    act_t                     data_p2;
    idx_t                     idx_p2;
    logic                     last_p2;

    // ---- stage p1: multiply ----
    // Product, index and last flag advance whenever the pipe moves
    always_ff @(posedge clk) begin
        if (en) begin
            product_p1 <= product;
            idx_p1     <= idx_p0;
            last_p1    <= last_p0;
        end
    end

    // Stage p1 valid; clear empties the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (clear) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= vld_p0;
        end
    end

    // ---- stage p2: round, clamp, output register ----
    // Output fields are zeroed by reset and clear and only reloaded by real words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            idx_p2  <= '0;
            last_p2 <= 1'b0;
        end else if (clear) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            idx_p2  <= '0;
            last_p2 <= 1'b0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= clamp_relu6(round_half_up(product_p1));
                idx_p2  <= idx_p1;
                last_p2 <= last_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_idx   = idx_p2;
    assign out_last  = last_p2;

endmodule

// File: rtl/dense1_bn_relu6_requant.sv
// Dense-1 BN + ReLU6 requantiser. Accepts one signed accumulator per
// neuron, looks up the neuron's scale through the external ROM, and emits
// an unsigned Q4.4 activation tagged with its neuron index three cycles
// later. A single stall condition (output held, sink not ready) freezes the
// whole pipe and drops in_ready.
module dense1_bn_relu6_requant
    import dense1_bn_relu6_requant_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int SHIFT     = SHIFT_DEF,
    parameter int RELU6_MAX = RELU6_MAX_DEF,
    parameter int N_NEURONS = N_NEURONS_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    dense1_bn_relu6_requant_if.slave        bus
);

    logic                    en;
    logic                    accept;
    idx_t                    idx_cnt;

    logic                    vld_p0;
    logic signed [ACC_W-1:0] acc_p0;
    logic [SCALE_W-1:0]      scale_p0;
    idx_t                    idx_p0;
    logic                    last_p0;

    logic                    out_valid_w;
    act_t                    out_data_w;
    idx_t                    out_idx_w;
    logic                    out_last_w;

    // The pipe moves unless a finished result is waiting on the sink
    assign en       = !(out_valid_w && !bus.out_ready);
    assign accept   = bus.in_valid && en;
    assign bus.in_ready = en;

    // The ROM always looks up the neuron that the next word belongs to
    assign bus.rom_addr = ADDR_W'(idx_cnt);

    // Neuron counter: one step per accepted word, restarted by clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_cnt <= '0;
        end else if (clear) begin
            idx_cnt <= '0;
        end else if (accept) begin
            idx_cnt <= next_idx(idx_cnt, N_NEURONS);
        end
    end

    // ---- stage p0: capture ----
    // Capture valid; a word arriving together with clear is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (clear) begin
            vld_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= bus.in_valid;
        end
    end

    // Accumulator, scale, index and last flag latched together on accept
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            acc_p0   <= bus.in_acc;
            scale_p0 <= bus.rom_data;
            idx_p0   <= idx_cnt;
            last_p0  <= (idx_cnt == idx_t'(N_NEURONS - 1));
        end
    end

    dense1_mul_round_clamp #(
        .ACC_W     (ACC_W),
        .SHIFT     (SHIFT),
        .RELU6_MAX (RELU6_MAX)
    ) u_mul_round_clamp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .en        (en),
        .vld_p0    (vld_p0),
        .acc_p0    (acc_p0),
        .scale_p0  (scale_p0),
        .idx_p0    (idx_p0),
        .last_p0   (last_p0),
        .out_valid (out_valid_w),
        .out_data  (out_data_w),
        .out_idx   (out_idx_w),
        .out_last  (out_last_w)
    );

    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.out_idx   = out_idx_w;
    assign bus.out_last  = out_last_w;

endmodule

// File: tb/tb_dense1_bn_relu6_requant.sv
// Directed bench for the dense-1 BN/ReLU6 requantiser: reset state,
// latency, clamp and rounding corners, backpressure, index wrap, and
// reset/clear in the middle of a vector.
module tb_dense1_bn_relu6_requant;
    import dense1_bn_relu6_requant_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    dense1_bn_relu6_requant_if #(.ACC_W(32)) bus();

    dense1_bn_relu6_requant dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    // Scale ROM model: combinational lookup on rom_addr
    logic [7:0] scale_rom [128];
    assign bus.rom_data = scale_rom[bus.rom_addr[6:0]];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int q_data[$];
    int q_idx[$];
    int q_last[$];
    int q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every activation the sink takes
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            q_data.push_back(int'(bus.out_data));
            q_idx.push_back(int'(bus.out_idx));
            q_last.push_back(int'(bus.out_last));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until in_ready (sampled mid-cycle) lets it in
    task automatic push(input logic signed [31:0] acc);
        bit rdy;
        int guard;
        rdy   = 1'b0;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_acc   = acc;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) chk("push_timeout", longint'(rdy), 1);
    endtask

    task automatic flush_q();
        q_data.delete();
        q_idx.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic clear_pulse();
        bus.in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        flush_q();
    endtask

    // Compare the k-th collected activation against expected fields
    task automatic check_out(input string tag, input int k, input int d, input int ix, input int l);
        if (k < q_data.size()) begin
            chk({tag, "_data"}, q_data[k], d);
            chk({tag, "_idx"},  q_idx[k],  ix);
            chk({tag, "_last"}, q_last[k], l);
        end else begin
            chk({tag, "_missing"}, q_data.size(), k + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_d [6];
        int acc_v [6];

        bus.in_valid  = 1'b0;
        bus.in_acc    = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 128; i++) scale_rom[i] = 8'd0;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_idx",   bus.out_idx,   0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_rom_addr",  bus.rom_addr,  0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_in_ready", bus.in_ready, 1);
        tick();
        chk("rel_in_ready2", bus.in_ready, 1);

        // ---- latency: 4096 * 0x5f -> 95 three cycles after accept ----
        scale_rom[0] = 8'h5f;
        bus.in_valid = 1'b1;
        bus.in_acc   = 32'sd4096;
        tick();
        bus.in_valid = 1'b0;
        chk("lat_c1_valid", bus.out_valid, 0);
        chk("lat_rom_addr", bus.rom_addr, 1);
        tick();
        chk("lat_c2_valid", bus.out_valid, 0);
        tick();
        chk("lat_c3_valid", bus.out_valid, 1);
        chk("lat_c3_data",  bus.out_data, 95);
        chk("lat_c3_idx",   bus.out_idx, 0);
        chk("lat_c3_last",  bus.out_last, 0);
        tick();
        chk("lat_c4_valid", bus.out_valid, 0);

        // ---- clamp and rounding corners, back to back ----
        clear_pulse();
        scale_rom[0] = 8'h40; acc_v[0] = -1000;  exp_d[0] = 0;
        scale_rom[1] = 8'h60; acc_v[1] = 8192;   exp_d[1] = 96;
        scale_rom[2] = 8'h01; acc_v[2] = 2048;   exp_d[2] = 1;
        scale_rom[3] = 8'h01; acc_v[3] = 2047;   exp_d[3] = 0;
        scale_rom[4] = 8'h01; acc_v[4] = -2048;  exp_d[4] = 0;
        scale_rom[5] = 8'd200; acc_v[5] = 1000;  exp_d[5] = 49;
        for (int k = 0; k < 6; k++) push(acc_v[k]);
        bus.in_valid = 1'b0;
        repeat (8) tick();
        chk("corner_count", q_data.size(), 6);
        for (int k = 0; k < 6; k++) check_out($sformatf("corner%0d", k), k, exp_d[k], k, 0);
        if (q_cyc.size() == 6) chk("corner_rate", q_cyc[5] - q_cyc[0], 5);

        // ---- backpressure: sink stalls for 5 cycles ----
        clear_pulse();
        for (int k = 0; k < 6; k++) scale_rom[k] = 8'h01;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) push((k + 1) * 40960);
                bus.in_valid = 1'b0;
            end
            begin
                tick();
                tick();
                chk("bp_c2_in_ready", bus.in_ready, 1);
                tick();
                tick();
                chk("bp_c4_in_ready",  bus.in_ready, 0);
                chk("bp_c4_out_valid", bus.out_valid, 1);
                chk("bp_c4_out_data",  bus.out_data, 10);
                tick();
                chk("bp_c5_in_ready",  bus.in_ready, 0);
                chk("bp_c5_out_data",  bus.out_data, 10);
                chk("bp_c5_out_idx",   bus.out_idx, 0);
                bus.out_ready = 1'b1;
            end
        join
        repeat (8) tick();
        chk("bp_count", q_data.size(), 6);
        for (int k = 0; k < 6; k++) check_out($sformatf("bp%0d", k), k, (k + 1) * 10, k, 0);

        // ---- wrap: 130 words through a 128-neuron vector ----
        clear_pulse();
        for (int i = 0; i < 128; i++) scale_rom[i] = 8'h01;
        for (int i = 0; i < 130; i++) begin
            chk($sformatf("wrap_rom_addr%0d", i), bus.rom_addr, i % 128);
            push(i * 4096);
        end
        bus.in_valid = 1'b0;
        repeat (8) tick();
        chk("wrap_count", q_data.size(), 130);
        for (int i = 0; i < 130; i++) begin
            check_out($sformatf("wrap%0d", i), i, (i > 96) ? 96 : i, i % 128,
                      ((i % 128) == 127) ? 1 : 0);
        end

        // ---- asynchronous reset in the middle of a vector ----
        clear_pulse();
        for (int k = 0; k < 5; k++) push((k + 50) * 4096);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data",  bus.out_data, 0);
        chk("mid_rst_out_idx",   bus.out_idx, 0);
        chk("mid_rst_rom_addr",  bus.rom_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        flush_q();
        push(7 * 4096);
        bus.in_valid = 1'b0;
        repeat (6) tick();
        chk("after_rst_count", q_data.size(), 1);
        check_out("after_rst", 0, 7, 0, 0);

        // ---- clear together with an accepted word ----
        for (int k = 0; k < 4; k++) push((k + 20) * 4096);
        chk("clr_pre_in_ready", bus.in_ready, 1);
        bus.in_acc   = 99 * 4096;
        bus.in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_out_valid", bus.out_valid, 0);
        chk("clr_out_data",  bus.out_data, 0);
        chk("clr_out_idx",   bus.out_idx, 0);
        chk("clr_rom_addr",  bus.rom_addr, 0);
        chk("clr_in_ready",  bus.in_ready, 1);
        flush_q();
        repeat (5) tick();
        chk("clr_dropped", q_data.size(), 0);
        push(9 * 4096);
        bus.in_valid = 1'b0;
        repeat (6) tick();
        chk("after_clr_count", q_data.size(), 1);
        check_out("after_clr", 0, 9, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
